pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single physical-memory port (256-bit line bus) between the I-cache and D-cache miss paths.
//  Sits between the two cache instances' pmem_* outputs and the memory/L2 interface.
//  Grants one requester at a time, holds the grant until pmem_resp, and alternates priority round-robin.
// PARAMETERS
//  s_line   256  line width in bits (pmem_rdata/pmem_wdata)
//  s_addr   32   address width in bits
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-low reset
//  i_pmem_read  in   1       I-cache line read request
//  i_pmem_write in   1       I-cache line write request (tied 0 in normal use; still arbitrated)
//  i_pmem_addr  in   s_addr  I-cache line address
//  i_pmem_wdata in   s_line  I-cache write line
//  i_pmem_rdata out  s_line  read line to I-cache
//  i_pmem_resp  out  1       completion pulse to I-cache
//  d_pmem_read  in   1       D-cache line read request
//  d_pmem_write in   1       D-cache line write request (writeback)
//  d_pmem_addr  in   s_addr  D-cache line address
//  d_pmem_wdata in   s_line  D-cache write line
//  d_pmem_rdata out  s_line  read line to D-cache
//  d_pmem_resp  out  1       completion pulse to D-cache
//  pmem_read    out  1       read strobe to memory
//  pmem_write   out  1       write strobe to memory
//  pmem_address out  s_addr  address to memory
//  pmem_wdata   out  s_line  write line to memory
//  pmem_rdata   in   s_line  read line from memory
//  pmem_resp    in   1       memory completion (one cycle per transaction)
// BEHAVIOUR
//  - Request from X = X_pmem_read | X_pmem_write. Requesters hold request and operands stable until their resp.
//  - FSM states: IDLE, GRANT_I, GRANT_D. Reset state IDLE; last_grant register resets to D (I wins the first tie).
//  - IDLE: if only I requests -> GRANT_I; only D -> GRANT_D; both -> the one not equal to last_grant. None -> stay.
//  - On entry to GRANT_x: latch op (write wins if read and write are both high), address and wdata into
//    output registers; update last_grant to x.
//  - GRANT_x: pmem_read/pmem_write driven from latched op for every cycle until pmem_resp; inputs are not
//    resampled. On pmem_resp: x_pmem_resp=1 combinationally that cycle, pmem_read/write drop next cycle, -> IDLE.
//  - One IDLE cycle between transactions (minimum); pmem strobe rises the cycle after the request is seen in IDLE.
//  - x_pmem_rdata = pmem_rdata unconditionally (only meaningful with x_pmem_resp); non-granted resp is always 0.
//  - pmem_resp while IDLE is ignored (no resp forwarded, no state change).
//  - Requester dropping its request mid-grant: transaction still completes; resp still forwarded.
//  - Reset (rst=0) at any time, including mid-transaction: pmem_read=pmem_write=0, pmem_address=0,
//    pmem_wdata=0, both resp=0, state IDLE immediately (asynchronous); outstanding transaction abandoned.
//  - No transaction is ever issued with pmem_read and pmem_write both high.
// TESTING
//  1 Reset: rst=0 with requests active -> all pmem strobes/resp 0, state IDLE; release -> normal operation.
//  2 I-only read addr 0x0000_0040: strobe at +1 cycle, memory resp after 5 cycles with rdata=A5..A5
//    -> i_pmem_resp=1 same cycle, i_pmem_rdata=A5..A5, d_pmem_resp stays 0.
//  3 Simultaneous I read 0x100 / D write 0x200 from reset -> I served first, then D (pmem_write, addr 0x200,
//    wdata passed); repeat both -> D first next tie (alternation verified over 4 ties).
//  4 D writeback 0x300 then immediate D read 0x300 -> two separate grants, write then read, IDLE gap between.
//  5 Spurious pmem_resp in IDLE -> no resp to either cache, no state change.
//  6 rst asserted 2 cycles into a D read -> strobe drops asynchronously; after release, re-request completes.

Source files
------------

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter sharing one physical-memory line port between I-cache and D-cache
module pmem_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [s_addr-1:0] i_pmem_addr,
    input  logic [s_line-1:0] i_pmem_wdata,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_addr,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_d;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [s_addr-1:0] r_pmem_address;
    logic [s_line-1:0] r_pmem_wdata;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_i;

    assign w_req_i  = i_pmem_read | i_pmem_write;
    assign w_req_d  = d_pmem_read | d_pmem_write;
    // On a tie the requester that was not served last time wins.
    assign w_pick_i = w_req_i & (~w_req_d | r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_last_d       <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_i) begin
                        r_state        <= GRANT_I;
                        r_last_d       <= 1'b0;
                        r_pmem_write   <= i_pmem_write;
                        r_pmem_read    <= i_pmem_read & ~i_pmem_write;
                        r_pmem_address <= i_pmem_addr;
                        r_pmem_wdata   <= i_pmem_wdata;
                    end else if (w_req_d) begin
                        r_state        <= GRANT_D;
                        r_last_d       <= 1'b1;
                        r_pmem_write   <= d_pmem_write;
                        r_pmem_read    <= d_pmem_read & ~d_pmem_write;
                        r_pmem_address <= d_pmem_addr;
                        r_pmem_wdata   <= d_pmem_wdata;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = (r_state == GRANT_I) & pmem_resp;
    assign d_pmem_resp  = (r_state == GRANT_D) & pmem_resp;

endmodule
